// File: rtl/quickq_pkg.sv
// Shared types and default sizes for the QuickQ scan datapath.
`default_nettype none

package quickq_pkg;

  localparam int QQ_KEY_W = 16;
  localparam int QQ_DEPTH = 16;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_RD     = 4'b0010,
    S_CMP    = 4'b0100,
    S_APPEND = 4'b1000
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/quickq_addr_counter.sv
// Scan address counter: synchronous clear/increment, asynchronous active-low reset.
`default_nettype none

module quickq_addr_counter
  import quickq_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              incr,
  output logic [ADDR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (incr) begin
      value <= value + ADDR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/quickq_scan_datapath.sv
// Scans the sorted key RAM for a new key, executing the insert controller's advance/swap commands.
// Optional: QQ_STABLE_TIE_EN makes equal keys advance (FIFO order among equal keys).
`default_nettype none

module quickq_scan_datapath
  import quickq_pkg::*;
#(
  parameter int KEY_W  = QQ_KEY_W,
  parameter int DEPTH  = QQ_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [KEY_W-1:0]  in_key,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [KEY_W-1:0]  ram_rdata,
  output logic [KEY_W-1:0]  ram_wdata,
  output logic              ram_we,
  output logic              result,
  output logic              result_valid,
  input  logic              incr,
  input  logic              we,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  scan_state_t       state, state_nxt;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  entry;
  logic [KEY_W-1:0]  entry_cur;
  logic              entry_held;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   addr_plus1;
  logic              addr_clear;
  logic              addr_incr;
  logic              handshake;
  logic              cmd;
  logic              key_after;

  quickq_addr_counter #(.ADDR_W(ADDR_W)) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (addr_clear),
    .incr  (addr_incr),
    .value (addr)
  );

  assign in_ready   = (state == S_IDLE) && (count < FULL);
  assign handshake  = in_valid && in_ready;
  assign cmd        = incr || we;
  assign addr_plus1 = {1'b0, addr} + (ADDR_W+1)'(1);
  assign ram_addr   = addr;
  // RAM output is only valid on the first compare cycle; afterwards use the captured copy.
  assign entry_cur  = entry_held ? entry : ram_rdata;

`ifdef QQ_STABLE_TIE_EN
  assign key_after = (key >= entry_cur);
`else
  assign key_after = (key > entry_cur);
`endif

  always_comb begin
    state_nxt    = state;
    addr_clear   = 1'b0;
    addr_incr    = 1'b0;
    ram_we       = 1'b0;
    ram_wdata    = key;
    result       = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (handshake) begin
          addr_clear = 1'b1;
          state_nxt  = (count == '0) ? S_APPEND : S_RD;
        end
      end
      S_RD: state_nxt = S_CMP;
      S_CMP: begin
        result_valid = 1'b1;
        result       = key_after;
        if (cmd) begin
          addr_incr = 1'b1;
          ram_we    = we;
          state_nxt = (addr_plus1 == count) ? S_APPEND : S_RD;
        end
      end
      S_APPEND: begin
        ram_we    = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      key        <= '0;
      entry      <= '0;
      entry_held <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      entry_held <= (state == S_CMP) && !cmd;
      if (state == S_CMP && !entry_held) begin
        entry <= ram_rdata;
      end
      if (handshake) begin
        key <= in_key;
      end else if (state == S_CMP && we) begin
        key <= entry_cur;
      end
      if (state == S_APPEND) begin
        count <= count + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_quickq_scan_datapath.sv
// Directed self-checking bench for quickq_scan_datapath with a behavioural sync RAM and insert controller.
`default_nettype none

module tb_quickq_scan_datapath;

  localparam int KEY_W  = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [KEY_W-1:0]  in_key = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [KEY_W-1:0]  ram_rdata;
  logic [KEY_W-1:0]  ram_wdata;
  logic              ram_we;
  logic              result;
  logic              result_valid;
  logic              incr = 1'b0;
  logic              we = 1'b0;
  logic              done;
  logic [ADDR_W:0]   count;

  logic [KEY_W-1:0]  mem [0:DEPTH-1];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  quickq_scan_datapath #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_key       (in_key),
    .in_ready     (in_ready),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .result       (result),
    .result_valid (result_valid),
    .incr         (incr),
    .we           (we),
    .done         (done),
    .count        (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; incr = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one key and plays the controller: advance on result=1, swap on result=0.
  task automatic insert(input logic [KEY_W-1:0] k, output int n_res,
                        output logic [15:0] res_bits, output int done_at);
    n_res = 0; res_bits = '0; done_at = -1;
    @(negedge clk);
    check("ready_before_insert", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_key = k;
    @(posedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_valid = 1'b0; incr = 1'b0; we = 1'b0;
      if (done) begin
        done_at = i;
        break;
      end
      if (result_valid) begin
        res_bits[n_res] = result;
        n_res++;
        if (result) incr = 1'b1;
        else        we   = 1'b1;
      end
    end
    if (done_at < 0) check("insert_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int          nr;
  logic [15:0] rb;
  int          da;
  logic        saw_we;
  logic        saw_rv;

  initial begin
    apply_reset();

    // Reset values
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);

    // Insert into empty queue
    insert(16'd5, nr, rb, da);
    check("empty_done_at", 32'(da), 32'd0);
    check("empty_no_cmp", 32'(nr), 32'd0);
    check("empty_mem0", 32'(mem[0]), 32'd5);
    check("empty_count", 32'(count), 32'd1);
    @(negedge clk);
    check("empty_done_pulse", 32'(done), 32'd0);

    // {3,7} + 9 -> append at end
    apply_reset();
    insert(16'd3, nr, rb, da);
    insert(16'd7, nr, rb, da);
    insert(16'd9, nr, rb, da);
    check("app_ncmp", 32'(nr), 32'd2);
    check("app_res0", 32'(rb[0]), 32'd1);
    check("app_res1", 32'(rb[1]), 32'd1);
    check("app_done_at", 32'(da), 32'd4);
    check("app_mem2", 32'(mem[2]), 32'd9);
    check("app_count", 32'(count), 32'd3);

    // {3,7} + 5 -> swap at 1, append 7
    apply_reset();
    insert(16'd3, nr, rb, da);
    insert(16'd7, nr, rb, da);
    insert(16'd5, nr, rb, da);
    check("mid_ncmp", 32'(nr), 32'd2);
    check("mid_res0", 32'(rb[0]), 32'd1);
    check("mid_res1", 32'(rb[1]), 32'd0);
    check("mid_mem0", 32'(mem[0]), 32'd3);
    check("mid_mem1", 32'(mem[1]), 32'd5);
    check("mid_mem2", 32'(mem[2]), 32'd7);
    check("mid_count", 32'(count), 32'd3);

    // Fill with descending keys, then stall while full
    apply_reset();
    for (int k = DEPTH - 1; k >= 0; k--) insert(16'(k), nr, rb, da);
    check("full_count", 32'(count), 32'd16);
    for (int a = 0; a < DEPTH; a++) check($sformatf("full_mem%0d", a), 32'(mem[a]), 32'(a));
    @(negedge clk);
    in_valid = 1'b1; in_key = 16'd99;
    saw_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ram_we) saw_we = 1'b1;
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_no_write", 32'(saw_we), 32'd0);
    check("full_count_hold", 32'(count), 32'd16);
    in_valid = 1'b0;

    // Equal-key ordering
    apply_reset();
    insert(16'd4, nr, rb, da);
    insert(16'd4, nr, rb, da);
    check("tie_ncmp", 32'(nr), 32'd1);
`ifdef QQ_STABLE_TIE_EN
    check("tie_result", 32'(rb[0]), 32'd1);
`else
    check("tie_result", 32'(rb[0]), 32'd0);
`endif
    check("tie_count", 32'(count), 32'd2);

    // Asynchronous reset during compare with both commands high
    apply_reset();
    insert(16'd3, nr, rb, da);
    insert(16'd7, nr, rb, da);
    @(negedge clk);
    in_valid = 1'b1; in_key = 16'd5;
    @(posedge clk);
    saw_rv = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (result_valid) begin
        saw_rv = 1'b1;
        break;
      end
    end
    check("arst_reach_cmp", 32'(saw_rv), 32'd1);
    incr = 1'b1; we = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_result_valid", 32'(result_valid), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_ram_we", 32'(ram_we), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_ram_addr", 32'(ram_addr), 32'd0);
    @(negedge clk);
    incr = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_count_after", 32'(count), 32'd0);
    check("arst_mem1_kept", 32'(mem[1]), 32'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
